fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter NOP_INST, 32'h0000_0000, instruction word placed in IF/ID for a bubble (sll $0,$0,0).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 stall  in  1  decode stall request.
REQ-006 remain_pc  in  1  with stall: hold PC and IF/ID.
REQ-007 branch  in  1  decode redirect request (taken branch, j, jal or jr).
REQ-008 jump  in  1  with branch: absolute jump (j/jal).
REQ-009 jr  in  1  with branch: register jump.
REQ-010 id_pc4  in  32  PC+4 of the instruction in decode.
REQ-011 id_imm  in  32  sign-extended branch offset, in words.
REQ-012 id_jaddr  in  26  jump target field.
REQ-013 id_rs_data  in  32  forwarded rs value for jr.
REQ-014 imem_req  out  1  instruction fetch request.
REQ-015 imem_addr  out  32  fetch byte address.
REQ-016 imem_ready  in  1  fetch complete; imem_rdata valid in the same cycle.
REQ-017 imem_rdata  in  32  fetched instruction.
REQ-018 pc  out  32  current PC register.
REQ-019 if_id_inst  out  32  registered instruction to decode.
REQ-020 if_id_pc4  out  32  registered PC+4 to decode.
REQ-021 if_id_valid  out  1  1 = if_id_inst is real, 0 = bubble.

Function
REQ-022 hold = stall & remain_pc; redirect = branch & ~hold; flush = redirect | (stall & ~remain_pc).
REQ-023 Target priority: jr -> id_rs_data; else jump -> {id_pc4[31:28], id_jaddr, 2'b00}; else id_pc4 + {id_imm[29:0], 2'b00}, modulo 2^32.
REQ-024 States: FETCH (imem_req=1, imem_addr=pc), BUF (fetched word held while stalled, imem_req=0), DRAIN (outstanding fetch to be discarded, imem_req=1, imem_addr=pc).
REQ-025 imem_addr and imem_req shall remain stable from assertion until the imem_ready cycle; PC never changes while a request is unacknowledged.
REQ-026 FETCH, imem_ready, no flush, no hold: IF/ID <= {rdata, pc+4, valid=1}; pc <= pc+4; stay FETCH.
REQ-027 FETCH, imem_ready, hold: buffer <= {rdata, pc+4}; pc <= pc+4; IF/ID unchanged; go BUF.
REQ-028 FETCH, imem_ready, flush: rdata discarded; IF/ID <= bubble; pc <= target on redirect, else pc+4; stay FETCH.
REQ-029 FETCH, ~imem_ready: hold keeps IF/ID; flush or otherwise IF/ID <= bubble; redirect latches target into pending register and enters DRAIN.
REQ-030 BUF: redirect discards buffer, pc <= target, IF/ID <= bubble, go FETCH; stall & ~remain_pc discards buffer, IF/ID <= bubble, go FETCH; hold keeps everything; else IF/ID <= buffer (valid=1), go FETCH.
REQ-031 DRAIN: IF/ID = bubble; redirect overwrites pending target (latest wins); on imem_ready rdata discarded, pc <= pending, go FETCH.
REQ-032 Bubble = {NOP_INST, pc4 32'h0, valid 0}.
REQ-033 Throughput one instruction per cycle when imem_ready held high and no hold/flush.

Reset
REQ-034 While rst=1: pc=RESET_PC, state FETCH, IF/ID = bubble, buffer and pending cleared, imem_req=0.
REQ-035 Reset mid-request or in BUF/DRAIN abandons all in-flight data; first request after release is to RESET_PC.

Verification
REQ-036 Release reset, imem_ready=1, rdata=i0,i1,i2 -> addresses 0,4,8; IF/ID valid from cycle 2 with pc4=4,8,12.
REQ-037 stall=remain_pc=1 for 2 cycles during ready fetch -> BUF entered, imem_req=0, IF/ID stable; on release buffered word delivered, next address +4, no loss/duplication.
REQ-038 branch=1, id_pc4=0x100, id_imm=0xFFFF_FFFC -> next imem_addr 0xF0, IF/ID bubble one cycle.
REQ-039 imem_ready=0 for 3 cycles, redirect jr with id_rs_data=0x400 in cycle 1 -> addr held, returned word discarded, next fetch 0x400.
REQ-040 jump=branch=1, id_pc4=0x9000_0010, id_jaddr=26'h10 -> next imem_addr 0x9000_0040; simultaneous hold suppresses redirect.
REQ-041 rst asserted while in DRAIN -> outputs immediately bubble, pc=RESET_PC, first post-reset fetch 0x0.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage with PC, IF/ID register, one-word stall buffer and redirect drain.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        remain_pc,
    input  logic        branch,
    input  logic        jump,
    input  logic        jr,
    input  logic [31:0] id_pc4,
    input  logic [31:0] id_imm,
    input  logic [25:0] id_jaddr,
    input  logic [31:0] id_rs_data,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] if_id_inst,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid
);
    typedef enum logic [1:0] {FETCH, BUF, DRAIN} state_t;
    state_t state_q, state_d;
    logic [31:0] pc_q, pc_d, inst_q, inst_d, pc4_q, pc4_d;
    logic [31:0] buf_inst_q, buf_inst_d, buf_pc4_q, buf_pc4_d, pend_q, pend_d;
    logic        valid_q, valid_d, bubble;
    logic        hold, redirect, kill, flush;
    logic [31:0] target, pc_inc;

    assign hold      = stall & remain_pc;
    assign redirect  = branch & ~hold;
    assign kill      = stall & ~remain_pc;
    assign flush     = redirect | kill;
    assign pc_inc    = pc_q + 32'd4;
    assign target    = jr ? id_rs_data : jump ? {id_pc4[31:28], id_jaddr, 2'b00} : id_pc4 + (id_imm << 2);
    assign imem_req  = ~rst & (state_q != BUF);
    assign imem_addr = pc_q;
    assign pc          = pc_q;
    assign if_id_inst  = inst_q;
    assign if_id_pc4   = pc4_q;
    assign if_id_valid = valid_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        pc4_d      = pc4_q;
        valid_d    = valid_q;
        buf_inst_d = buf_inst_q;
        buf_pc4_d  = buf_pc4_q;
        pend_d     = pend_q;
        bubble     = 1'b0;
        case (state_q)
            FETCH: begin
                if (imem_ready) begin
                    pc_d = pc_inc;
                    if (hold) begin
                        buf_inst_d = imem_rdata;
                        buf_pc4_d  = pc_inc;
                        state_d    = BUF;
                    end else if (flush) begin
                        bubble = 1'b1;
                        pc_d   = redirect ? target : pc_inc;
                    end else begin
                        inst_d  = imem_rdata;
                        pc4_d   = pc_inc;
                        valid_d = 1'b1;
                    end
                end else begin
                    bubble = ~hold;
                    // the in-flight word must still be accepted before the PC may move
                    if (redirect) begin
                        pend_d  = target;
                        state_d = DRAIN;
                    end
                end
            end
            BUF: begin
                if (!hold) begin
                    state_d = FETCH;
                    bubble  = flush;
                    pc_d    = redirect ? target : pc_q;
                    if (!flush) begin
                        inst_d  = buf_inst_q;
                        pc4_d   = buf_pc4_q;
                        valid_d = 1'b1;
                    end
                end
            end
            DRAIN: begin
                bubble = 1'b1;
                pend_d = redirect ? target : pend_q;
                if (imem_ready) begin
                    pc_d    = redirect ? target : pend_q;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
        if (bubble) begin
            inst_d  = NOP_INST;
            pc4_d   = 32'h0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            inst_q     <= NOP_INST;
            pc4_q      <= 32'h0;
            valid_q    <= 1'b0;
            buf_inst_q <= 32'h0;
            buf_pc4_q  <= 32'h0;
            pend_q     <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            pc4_q      <= pc4_d;
            valid_q    <= valid_d;
            buf_inst_q <= buf_inst_d;
            buf_pc4_q  <= buf_pc4_d;
            pend_q     <= pend_d;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed stimulus against a queue-based fetch model plus literal checkpoints.
module tb_fetch_stage;
    logic        clk = 1'b0, rst = 1'b1;
    logic        stall = 1'b0, remain_pc = 1'b0, branch = 1'b0, jump = 1'b0, jr = 1'b0, imem_ready = 1'b0;
    logic [31:0] id_pc4 = 32'h0, id_imm = 32'h0, id_rs_data = 32'h0;
    logic [25:0] id_jaddr = 26'h0;
    logic        imem_req, if_id_valid;
    logic [31:0] imem_addr, imem_rdata, pc, if_id_inst, if_id_pc4;
    int tests = 0, fails = 0;

    fetch_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .remain_pc(remain_pc), .branch(branch),
        .jump(jump), .jr(jr), .id_pc4(id_pc4), .id_imm(id_imm), .id_jaddr(id_jaddr),
        .id_rs_data(id_rs_data), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .pc(pc), .if_id_inst(if_id_inst),
        .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC000_0000 | a;
    endfunction
    assign imem_rdata = mem_word(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: fetched-but-undelivered words sit in a queue; a pending redirect waits for the old fetch.
    logic [31:0] mpc = 32'h0, m_inst = 32'h0, m_pc4 = 32'h0, dtgt = 32'h0;
    logic        m_valid = 1'b0, draining = 1'b0;
    logic [63:0] held[$];

    task automatic bub();
        m_inst  = 32'h0;
        m_pc4   = 32'h0;
        m_valid = 1'b0;
    endtask

    task automatic model_step();
        logic        h, rd, kl;
        logic [31:0] t;
        logic [63:0] w;
        if (rst) begin
            mpc = 32'h0;
            bub();
            held.delete();
            draining = 1'b0;
            dtgt = 32'h0;
            return;
        end
        h  = stall && remain_pc;
        rd = branch && !h;
        kl = stall && !remain_pc;
        t  = jr ? id_rs_data : jump ? ((id_pc4 & 32'hF000_0000) | ({6'b0, id_jaddr} * 4)) : id_pc4 + id_imm * 4;
        if (held.size() > 0) begin
            if (rd) begin held.delete(); mpc = t; bub(); end
            else if (kl) begin held.delete(); bub(); end
            else if (!h) begin
                w = held.pop_front();
                m_inst = w[63:32];
                m_pc4 = w[31:0];
                m_valid = 1'b1;
            end
        end else if (draining) begin
            bub();
            if (rd) dtgt = t;
            if (imem_ready) begin mpc = dtgt; draining = 1'b0; end
        end else if (imem_ready) begin
            if (h) begin
                held.push_back({mem_word(mpc), mpc + 32'd4});
                mpc = mpc + 32'd4;
            end else if (rd || kl) begin
                bub();
                mpc = rd ? t : mpc + 32'd4;
            end else begin
                m_inst = mem_word(mpc);
                m_pc4 = mpc + 32'd4;
                m_valid = 1'b1;
                mpc = mpc + 32'd4;
            end
        end else begin
            if (!h) bub();
            if (rd) begin draining = 1'b1; dtgt = t; end
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    always @(negedge clk) begin
        chk("req", 32'(imem_req), 32'(!rst && held.size() == 0));
        chk("addr", imem_addr, mpc);
        chk("pc", pc, mpc);
        chk("inst", if_id_inst, m_inst);
        chk("pc4", if_id_pc4, m_pc4);
        chk("valid", 32'(if_id_valid), 32'(m_valid));
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        repeat (3) step();
        @(negedge clk);
        chk("rst_pc", pc, 32'h0);
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_valid", 32'(if_id_valid), 32'h0);
        step(); rst = 1'b0; imem_ready = 1'b1;
        @(negedge clk);
        chk("first_addr", imem_addr, 32'h0);
        chk("first_req", 32'(imem_req), 32'h1);
        step(); @(negedge clk);
        chk("i0_inst", if_id_inst, 32'hC000_0000);
        chk("i0_pc4", if_id_pc4, 32'h4);
        chk("i1_addr", imem_addr, 32'h4);
        step(); @(negedge clk);
        chk("i1_pc4", if_id_pc4, 32'h8);
        step(); stall = 1'b1; remain_pc = 1'b1;
        @(negedge clk);
        chk("i2_pc4", if_id_pc4, 32'hC);
        step(); @(negedge clk);
        chk("buf_req", 32'(imem_req), 32'h0);
        chk("buf_pc4", if_id_pc4, 32'hC);
        step(); stall = 1'b0; remain_pc = 1'b0;
        @(negedge clk);
        chk("buf_hold_pc", pc, 32'h10);
        step(); @(negedge clk);
        chk("buf_out_inst", if_id_inst, 32'hC000_000C);
        chk("buf_out_addr", imem_addr, 32'h10);
        step(); branch = 1'b1; id_pc4 = 32'h100; id_imm = 32'hFFFF_FFFC;
        @(negedge clk);
        chk("pre_br_pc4", if_id_pc4, 32'h14);
        step(); branch = 1'b0;
        @(negedge clk);
        chk("br_addr", imem_addr, 32'hF0);
        chk("br_bubble", 32'(if_id_valid), 32'h0);
        step(); imem_ready = 1'b0; branch = 1'b1; jr = 1'b1; id_rs_data = 32'h400;
        @(negedge clk);
        chk("br_inst", if_id_inst, 32'hC000_00F0);
        step(); branch = 1'b0; jr = 1'b0;
        @(negedge clk);
        chk("drain_addr", imem_addr, 32'hF4);
        step(); @(negedge clk);
        chk("drain_addr2", imem_addr, 32'hF4);
        step(); imem_ready = 1'b1;
        step(); @(negedge clk);
        chk("jr_addr", imem_addr, 32'h400);
        chk("jr_bubble", 32'(if_id_valid), 32'h0);
        step(); branch = 1'b1; jump = 1'b1; stall = 1'b1; remain_pc = 1'b1;
        id_pc4 = 32'h9000_0010; id_jaddr = 26'h10;
        @(negedge clk);
        chk("jr_inst", if_id_inst, 32'hC000_0400);
        step(); stall = 1'b0; remain_pc = 1'b0;
        @(negedge clk);
        chk("hold_sup_pc", pc, 32'h408);
        step(); branch = 1'b0; jump = 1'b0;
        @(negedge clk);
        chk("j_addr", imem_addr, 32'h9000_0040);
        step(); imem_ready = 1'b0; branch = 1'b1; jr = 1'b1; id_rs_data = 32'h800;
        @(negedge clk);
        chk("j_inst", if_id_inst, 32'hD000_0040);
        step(); @(negedge clk);
        chk("drain2_bubble", 32'(if_id_valid), 32'h0);
        #1 rst = 1'b1; branch = 1'b0; jr = 1'b0;
        #1;
        chk("arst_pc", pc, 32'h0);
        chk("arst_req", 32'(imem_req), 32'h0);
        step(); rst = 1'b0; imem_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_addr", imem_addr, 32'h0);
        step(); @(negedge clk);
        chk("post_rst_pc4", if_id_pc4, 32'h4);
        for (int i = 0; i < 300; i++) begin
            step();
            rst        = (i >= 150 && i < 152);
            imem_ready = (i % 3 != 0);
            stall      = (i % 5 == 1) || (i % 13 == 7);
            remain_pc  = (i % 7 < 4);
            branch     = (i % 4 == 2);
            jump       = (i % 8 == 6);
            jr         = (i % 11 == 3);
            id_pc4     = i * 16;
            id_imm     = (i % 2 == 1) ? -i : i;
            id_jaddr   = 26'(i * 3);
            id_rs_data = i * 64;
        end
        step(); @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
